// File: rtl/pipe_scroller.sv
// Scrolling pipe buffer for a flappy-bird style game: 16 columns, IDLE/RUN/HIT control and a saturating score.
// Optional build macro PIPE_BIRD_OVERLAY_EN ORs the bird pixel into the readout of the bird column.
module pipe_scroller #(
    parameter int BIRD_COL = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [15:0] col_in,
    input  logic        start,
    input  logic [3:0]  bird_row,
    input  logic [3:0]  rd_col,
    output logic [15:0] rd_data,
    output logic        running,
    output logic        hit,
    output logic [7:0]  score
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HIT  = 2'd2;

    localparam logic [3:0] BIRD_IDX = BIRD_COL[3:0];

    logic [1:0]  state_q, state_d;
    logic [7:0]  score_q, score_d;
    logic [15:0] col_q [16];
    logic [15:0] col_d [16];
    logic        collision;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // The overlay is display-only; collision always looks at the raw buffer.
    assign collision = (state_q == S_RUN) && col_q[BIRD_IDX][bird_row];

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        for (int i = 0; i < 16; i++) col_d[i] = col_q[i];
        case (state_q)
            S_IDLE, S_HIT: begin
                if (start) begin
                    state_d = S_RUN;
                    score_d = 8'd0;
                    for (int i = 0; i < 16; i++) col_d[i] = 16'h0000;
                end
            end
            S_RUN: begin
                // Collision wins over a simultaneous tick: the buffer freezes as hit.
                if (collision) begin
                    state_d = S_HIT;
                end else if (tick) begin
                    for (int i = 0; i < 15; i++) col_d[i] = col_q[i+1];
                    col_d[15] = col_in;
                    if (col_q[BIRD_IDX] != 16'h0000) score_d = sat_inc(score_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            score_q <= 8'd0;
            for (int i = 0; i < 16; i++) col_q[i] <= 16'h0000;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            for (int i = 0; i < 16; i++) col_q[i] <= col_d[i];
        end
    end

    assign running = (state_q == S_RUN);
    assign hit     = (state_q == S_HIT);
    assign score   = score_q;

`ifdef PIPE_BIRD_OVERLAY_EN
    assign rd_data = col_q[rd_col] | ((rd_col == BIRD_IDX) ? (16'd1 << bird_row) : 16'd0);
`else
    assign rd_data = col_q[rd_col];
`endif

endmodule

// File: tb/tb_pipe_scroller.sv
// Randomised and directed bench for pipe_scroller against a queue-based game model.
module tb_pipe_scroller;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [15:0] col_in;
    logic        start;
    logic [3:0]  bird_row;
    logic [3:0]  rd_col;
    logic [15:0] rd_data;
    logic        running;
    logic        hit;
    logic [7:0]  score;

    int checks = 0;
    int errors = 0;

    pipe_scroller #(.BIRD_COL(BC)) dut (
        .clk(clk), .reset(reset), .tick(tick), .col_in(col_in), .start(start),
        .bird_row(bird_row), .rd_col(rd_col), .rd_data(rd_data),
        .running(running), .hit(hit), .score(score)
    );

    always #5 clk = ~clk;

    // Model: the screen is a queue of 16 columns, front = leftmost.
    logic [15:0] mq[$];
    int          m_state;   // 0 idle, 1 running, 2 crashed
    int          m_score;

    function automatic void model_clear();
        mq.delete();
        for (int i = 0; i < 16; i++) mq.push_back(16'h0000);
        m_score = 0;
    endfunction

    function automatic void model_reset();
        model_clear();
        m_state = 0;
    endfunction

    function automatic void model_step();
        logic [15:0] bc;
        bit          crash;
        bc = mq[BC];
        crash = (m_state == 1) && bc[bird_row];
        if (m_state != 1) begin
            if (start) begin
                model_clear();
                m_state = 1;
            end
        end else if (crash) begin
            m_state = 2;
        end else if (tick) begin
            if (bc != 16'h0000 && m_score < 255) m_score = m_score + 1;
            void'(mq.pop_front());
            mq.push_back(col_in);
        end
    endfunction

    function automatic logic [15:0] exp_rd(input logic [3:0] c);
        logic [15:0] v;
        v = mq[c];
`ifdef PIPE_BIRD_OVERLAY_EN
        if (int'(c) == BC) v = v | (16'd1 << bird_row);
`endif
        return v;
    endfunction

    task automatic do_cycle(input logic t, input logic s, input logic [15:0] c);
        tick = t; start = s; col_in = c;
        model_step();
        @(posedge clk);
        #1;
        tick = 1'b0; start = 1'b0; col_in = 16'h0000;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        model_reset();
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        int guard;
        reset = 1'b0; tick = 0; start = 0; col_in = 0; bird_row = 4'd10; rd_col = 0;
        model_reset();
        #2;
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL por_running got %b want 0", running); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL por_hit got %b want 0", hit); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL por_score got %0d want 0", score); end
        #1 reset = 1'b1;
        @(posedge clk); #1;
        // Reach score 5 while running, then pull reset between edges.
        do_cycle(0, 1, 16'h0);
        for (int k = 0; k < 5; k++) do_cycle(1, 0, 16'hE1FF);
        guard = 0;
        while (m_score < 5 && guard < 40) begin do_cycle(1, 0, 16'h0); guard++; end
        checks++; if (score !== 8'(m_score) || m_score != 5) begin errors++; $display("FAIL pre_reset_score got %0d want 5 (model %0d)", score, m_score); end
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running got %b want 0", running); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rst_hit got %b want 0", hit); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL rst_score got %0d want 0", score); end
        for (int c = 0; c < 16; c++) begin
            rd_col = 4'(c);
            #0.1;
            checks++; if (rd_data !== exp_rd(4'(c))) begin errors++; $display("FAIL rst_rd col %0d got %h want %h", c, rd_data, exp_rd(4'(c))); end
        end
        #1 reset = 1'b1;
        // Ticks after reset are ignored until a new start.
        for (int k = 0; k < 3; k++) do_cycle(1, 0, 16'hFFFF);
        rd_col = 4'd15; #0.1;
        checks++; if (running !== 1'b0 || rd_data !== exp_rd(4'd15)) begin errors++; $display("FAIL idle_tick running %b rd %h want 0 %h", running, rd_data, exp_rd(4'd15)); end
    endtask

    task automatic test_scroll_pass();
        bird_row = 4'd10;
        do_cycle(0, 1, 16'h0);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running got %b want 1", running); end
        do_cycle(1, 0, 16'hE1FF);
        rd_col = 4'd15; #0.1;
        checks++; if (rd_data !== exp_rd(4'd15) || exp_rd(4'd15) !== 16'hE1FF) begin errors++; $display("FAIL scroll_t1 got %h want %h", rd_data, exp_rd(4'd15)); end
        for (int k = 2; k <= 14; k++) do_cycle(1, 0, 16'h0);
        rd_col = 4'd2; #0.1;
        checks++; if (rd_data !== exp_rd(4'd2)) begin errors++; $display("FAIL scroll_t14 got %h want %h", rd_data, exp_rd(4'd2)); end
        do_cycle(1, 0, 16'h0);
        checks++; if (running !== 1'b1 || score !== 8'(m_score) || m_score != 1) begin errors++; $display("FAIL pass_t15 running %b score %0d want 1 %0d", running, score, m_score); end
        do_cycle(0, 1, 16'h0);
        rd_col = 4'd1; #0.1;
        checks++; if (rd_data !== exp_rd(4'd1) || score !== 8'(m_score)) begin errors++; $display("FAIL start_in_run rd %h score %0d want %h %0d", rd_data, score, exp_rd(4'd1), m_score); end
    endtask

    task automatic test_collision();
        apply_reset();
        bird_row = 4'd3;
        do_cycle(0, 1, 16'h0);
        do_cycle(1, 0, 16'hE1FF);
        for (int k = 2; k <= 14; k++) do_cycle(1, 0, 16'h0);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_early got %b want 0", hit); end
        do_cycle(1, 0, 16'hFFFF);
        rd_col = 4'd15; #0.1;
        checks++; if (hit !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL hit_edge hit %b running %b want 1 0", hit, running); end
        checks++; if (rd_data !== exp_rd(4'd15)) begin errors++; $display("FAIL prio_noshift got %h want %h", rd_data, exp_rd(4'd15)); end
        for (int k = 0; k < 3; k++) do_cycle(1, 0, 16'hFFFF);
        rd_col = 4'd2; #0.1;
        checks++; if (rd_data !== exp_rd(4'd2) || score !== 8'd0) begin errors++; $display("FAIL hit_frozen rd %h score %0d want %h 0", rd_data, score, exp_rd(4'd2)); end
    endtask

    task automatic test_saturation_restart();
        apply_reset();
        bird_row = 4'd10;
        do_cycle(0, 1, 16'h0);
        for (int k = 0; k < 280; k++) begin
            do_cycle(1, 0, 16'hE1FF);
            checks++; if (score !== 8'(m_score)) begin errors++; $display("FAIL sat_step %0d got %0d want %0d", k, score, m_score); end
        end
        checks++; if (score !== 8'd255) begin errors++; $display("FAIL sat_final got %0d want 255", score); end
        bird_row = 4'd0;
        do_cycle(1, 0, 16'h0);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL sat_hit got %b want 1", hit); end
        do_cycle(0, 1, 16'h0);
        checks++; if (running !== 1'b1 || hit !== 1'b0 || score !== 8'd0) begin errors++; $display("FAIL restart running %b hit %b score %0d want 1 0 0", running, hit, score); end
        for (int c = 0; c < 16; c++) begin
            rd_col = 4'(c); #0.1;
            checks++; if (rd_data !== exp_rd(4'(c))) begin errors++; $display("FAIL restart_rd col %0d got %h want %h", c, rd_data, exp_rd(4'(c))); end
        end
    endtask

    task automatic test_overlay();
        logic [15:0] want;
        apply_reset();
        bird_row = 4'd7;
        rd_col = 4'd2;
        #0.1;
`ifdef PIPE_BIRD_OVERLAY_EN
        want = 16'h0080;
`else
        want = 16'h0000;
`endif
        checks++; if (rd_data !== want) begin errors++; $display("FAIL overlay got %h want %h", rd_data, want); end
    endtask

    task automatic test_random();
        logic [15:0] c;
        logic [3:0]  gap;
        apply_reset();
        bird_row = 4'd8;
        do_cycle(0, 1, 16'h0);
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 19) == 0) bird_row = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) begin
                gap = 4'($urandom_range(0, 12));
                c = ~(16'hF << gap);
                c = c | ~(16'hFFFF >> (12 - gap));
                c = ~(16'hF << gap) & 16'hFFFF ^ 16'h0;
                c = 16'hFFFF & ~(16'hF << gap);
            end else begin
                c = 16'h0;
            end
            do_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, c);
            rd_col = 4'($urandom_range(0, 15));
            #0.1;
            checks++;
            if (running !== (m_state == 1) || hit !== (m_state == 2) || score !== 8'(m_score) || rd_data !== exp_rd(rd_col)) begin
                errors++;
                $display("FAIL random %0d run %b hit %b score %0d rd[%0d] %h want %b %b %0d %h",
                         k, running, hit, score, rd_col, rd_data, m_state == 1, m_state == 2, m_score, exp_rd(rd_col));
            end
        end
    endtask

    initial begin
        test_reset();
        test_scroll_pass();
        test_collision();
        test_saturation_restart();
        test_overlay();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_scroller.md
PIPE_SCROLLER -- requirements
Module: pipe_scroller

Interface
REQ-001 SHALL have parameter BIRD_COL, default 2, meaning the buffer column (1..14) occupied by the bird.
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port tick  input  1  one-cycle scroll strobe, synchronous to clk.
REQ-005 SHALL have port col_in  input  16  incoming pipe column from the generator; 1 = lit pipe cell, 16'b0 = empty column.
REQ-006 SHALL have port start  input  1  one-cycle game start/restart strobe.
REQ-007 SHALL have port bird_row  input  4  the bird's current row, 0..15.
REQ-008 SHALL have port rd_col  input  4  display readout column select.
REQ-009 SHALL have port rd_data  output  16  combinational contents of the selected column.
REQ-010 SHALL have port running  output  1  high while in state RUN.
REQ-011 SHALL have port hit  output  1  high while in state HIT.
REQ-012 SHALL have port score  output  8  count of pipes passed.

Function
REQ-013 SHALL hold a 16 x 16-bit column buffer: col[15] is newest/rightmost and col[0] is oldest/leftmost.
REQ-014 SHALL implement states IDLE, RUN and HIT.
REQ-015 SHALL have the following transitions, and no others:
- IDLE->RUN on start.
- RUN->HIT on collision.
- HIT->RUN on start.
REQ-016 SHALL, on any start accepted in IDLE or HIT, clear the buffer and score in that same edge.
REQ-017 SHALL ignore start while in RUN.
REQ-018 SHALL, on tick in RUN with no collision, do the following in one edge:
- col[i] <= col[i+1] for i = 0..14.
- col[15] <= col_in.
REQ-019 SHALL ignore tick in IDLE and HIT; buffer and score stay frozen.
REQ-020 SHALL define collision as RUN && col[BIRD_COL][bird_row] == 1, evaluated every cycle.
REQ-021 SHALL enter HIT on the edge after collision is first true; hit and running update on that same edge.
REQ-022 SHALL give collision priority over a simultaneous tick: no shift, no score increment.
REQ-023 SHALL increment score on an accepted shift when col[BIRD_COL] != 0 before the shift (a pipe column leaving the bird column).
REQ-024 SHALL saturate score at 255; no wrap-around.
REQ-025 SHALL drive rd_data = col[rd_col] combinationally, with zero latency.
REQ-026 SHALL keep col_in width and bit ordering identical to the generator: bit 15 is the top row.

Reset
REQ-027 SHALL, while reset is low, asynchronously force all of the following, independent of clk:
- state = IDLE.
- all buffer columns = 0.
- score = 0.
- running = 0, hit = 0.
REQ-028 SHALL, with reset deasserted mid-RUN, resume from IDLE only and require a new start.
REQ-029 SHALL, on reset, produce rd_data = 16'b0 for every rd_col.

Configuration
REQ-030 SHALL, with macro PIPE_BIRD_OVERLAY_EN defined, drive rd_data = col[BIRD_COL] | (16'b1 << bird_row) when rd_col == BIRD_COL in any state.
REQ-031 SHALL, without PIPE_BIRD_OVERLAY_EN, drive rd_data as pure buffer contents; the overlay does not affect collision or score in either build.

Verification
REQ-032 SHALL cover reset: reset low mid-RUN with score = 5 -> immediately running = 0, hit = 0, score = 0, rd_data = 0 for all 16 rd_col.
REQ-033 SHALL cover scroll: start, then tick with col_in = 16'hE1FF followed by 16'h0 -> after 1 tick rd_col = 15 reads 16'hE1FF; after 14 ticks rd_col = 2 reads 16'hE1FF.
REQ-034 SHALL cover pass-through: as REQ-033 with bird_row = 10 (gap) -> running stays 1, and score = 1 after tick 15.
REQ-035 SHALL cover collision: as REQ-033 with bird_row = 3 -> hit = 1 one edge after tick 14; further ticks leave the buffer frozen and score = 0.
REQ-036 SHALL cover priority and saturation:
- collision cycle with tick high -> no shift.
- 256 scored pipes -> score = 255.
- start in HIT -> running = 1, buffer and score = 0.
REQ-037 SHALL cover overlay: with PIPE_BIRD_OVERLAY_EN, an empty buffer and bird_row = 7 -> rd_col = 2 reads 16'h0080; without it -> 16'h0000.
